// File: rtl/sump_cmd_decoder.sv
// SUMP command decoder: frames the SPI receive byte stream into short
// (1-byte) and long (opcode + 4 data bytes) commands, issues a registered
// execute strobe with decoded pulses, and drops a partial long command
// when the inter-byte gap exceeds TIMEOUT_CYCLES.
module sump_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        extReset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  opcode,
  output logic [31:0] cmd_data,
  output logic        execute,
  output logic        cmd_busy,
  output logic        cmd_abort,
  output logic        soft_reset,
  output logic        arm,
  output logic        query_id,
  output logic        query_metadata,
  output logic        finish_now
);

  // Counter value seen in the last idle cycle before expiry; a byte arriving
  // in that same cycle still wins over the timeout.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OP_SOFT_RESET = 8'h00;
  localparam logic [7:0] OP_ARM        = 8'h01;
  localparam logic [7:0] OP_QUERY_ID   = 8'h02;
  localparam logic [7:0] OP_QUERY_META = 8'h04;
  localparam logic [7:0] OP_FINISH     = 8'h05;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    GETDATA = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  byte_cnt;
  logic [15:0] idle_cnt;
  logic [7:0]  op_shadow;
  logic [23:0] data_shadow;

  logic take_short;
  logic take_long_op;
  logic take_data;
  logic finish_long;
  logic timeout;

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (extReset) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic and per-cycle datapath controls.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_next   = state;
    take_short   = 1'b0;
    take_long_op = 1'b0;
    take_data    = 1'b0;
    finish_long  = 1'b0;
    timeout      = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_valid) begin
          if (!rx_byte[7]) begin
            take_short = 1'b1;
          end else begin
            take_long_op = 1'b1;
            state_next   = GETDATA;
          end
        end
      end
      GETDATA: begin
        if (rx_valid) begin
          take_data = 1'b1;
          if (byte_cnt == 2'd3) begin
            finish_long = 1'b1;
            state_next  = IDLE;
          end
        end else if (idle_cnt == TIMEOUT_LAST) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shadow capture, byte counter and inter-byte timeout counter.
  always_ff @(posedge clock) begin
    if (extReset) begin
      op_shadow   <= '0;
      data_shadow <= '0;
      byte_cnt    <= '0;
      idle_cnt    <= '0;
    end else begin
      if (take_long_op) begin
        op_shadow <= rx_byte;
        byte_cnt  <= '0;
      end
      if (take_data) begin
        unique case (byte_cnt)
          2'd0:    data_shadow[7:0]   <= rx_byte;
          2'd1:    data_shadow[15:8]  <= rx_byte;
          2'd2:    data_shadow[23:16] <= rx_byte;
          default: ;
        endcase
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (timeout) begin
        op_shadow   <= '0;
        data_shadow <= '0;
        byte_cnt    <= '0;
      end
      // Counts only idle cycles of a partial long command; held at 0 otherwise.
      if (state == GETDATA && !rx_valid && !timeout) idle_cnt <= idle_cnt + 16'd1;
      else                                            idle_cnt <= '0;
    end
  end

  // Registered command outputs and decoded one-cycle pulses.
  always_ff @(posedge clock) begin
    if (extReset) begin
      opcode         <= '0;
      cmd_data       <= '0;
      execute        <= 1'b0;
      cmd_busy       <= 1'b0;
      cmd_abort      <= 1'b0;
      soft_reset     <= 1'b0;
      arm            <= 1'b0;
      query_id       <= 1'b0;
      query_metadata <= 1'b0;
      finish_now     <= 1'b0;
    end else begin
      execute        <= take_short | finish_long;
      cmd_busy       <= (state_next == GETDATA);
      cmd_abort      <= timeout;
      soft_reset     <= take_short && (rx_byte == OP_SOFT_RESET);
      arm            <= take_short && (rx_byte == OP_ARM);
      query_id       <= take_short && (rx_byte == OP_QUERY_ID);
      query_metadata <= take_short && (rx_byte == OP_QUERY_META);
      finish_now     <= take_short && (rx_byte == OP_FINISH);
      if (take_short) opcode <= rx_byte;
      if (finish_long) begin
        opcode   <= op_shadow;
        cmd_data <= {rx_byte, data_shadow};
      end
    end
  end

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Table-driven bench for sump_cmd_decoder with TIMEOUT_CYCLES=8. Each table
// row is one clock: inputs driven before the edge, expected outputs sampled
// 1 ns after it. A hand-written sequence then measures the abort latency.
module tb_sump_cmd_decoder;

  localparam int unsigned TMO = 8;

  logic        clk;
  logic        ext_reset;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  opcode;
  logic [31:0] cmd_data;
  logic        execute;
  logic        cmd_busy;
  logic        cmd_abort;
  logic        soft_reset;
  logic        arm;
  logic        query_id;
  logic        query_metadata;
  logic        finish_now;

  int checks   = 0;
  int failures = 0;

  sump_cmd_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock          (clk),
    .extReset       (ext_reset),
    .rx_byte        (rx_byte),
    .rx_valid       (rx_valid),
    .opcode         (opcode),
    .cmd_data       (cmd_data),
    .execute        (execute),
    .cmd_busy       (cmd_busy),
    .cmd_abort      (cmd_abort),
    .soft_reset     (soft_reset),
    .arm            (arm),
    .query_id       (query_id),
    .query_metadata (query_metadata),
    .finish_now     (finish_now)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse vector order: {soft_reset, arm, query_id, query_metadata, finish_now}
  typedef struct {
    bit          rst;
    bit          vld;
    logic [7:0]  byt;
    bit          ex;
    bit          busy;
    bit          ab;
    logic [4:0]  pulses;
    logic [7:0]  op;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic v(input bit r, input bit vld, input logic [7:0] b, input bit ex,
                   input bit busy, input bit ab, input logic [4:0] p,
                   input logic [7:0] op, input logic [31:0] d);
    vec_t t;
    t.rst = r; t.vld = vld; t.byt = b; t.ex = ex; t.busy = busy;
    t.ab = ab; t.pulses = p; t.op = op; t.data = d;
    vecs.push_back(t);
  endtask

  // Idle cycle with the given expected held state.
  task automatic idle(input int n, input bit busy, input logic [7:0] op, input logic [31:0] d);
    for (int i = 0; i < n; i++) v(0, 0, 8'h00, 0, busy, 0, 5'b0, op, d);
  endtask

  initial begin
    ext_reset = 1'b1;
    rx_valid  = 1'b0;
    rx_byte   = 8'h00;

    // Reset state.
    v(1, 0, 8'h00, 0, 0, 0, 5'b0, 8'h00, 32'h0);
    v(1, 0, 8'h00, 0, 0, 0, 5'b0, 8'h00, 32'h0);
    idle(7, 0, 8'h00, 32'h0);
    // Short query_metadata.
    v(0, 1, 8'h04, 1, 0, 0, 5'b00010, 8'h04, 32'h0);
    idle(1, 0, 8'h04, 32'h0);
    // Long command, one byte per clock, no decoded pulse.
    v(0, 1, 8'hC0, 0, 1, 0, 5'b0, 8'h04, 32'h0);
    v(0, 1, 8'h78, 0, 1, 0, 5'b0, 8'h04, 32'h0);
    v(0, 1, 8'h56, 0, 1, 0, 5'b0, 8'h04, 32'h0);
    v(0, 1, 8'h34, 0, 1, 0, 5'b0, 8'h04, 32'h0);
    v(0, 1, 8'h12, 1, 0, 0, 5'b0, 8'hC0, 32'h12345678);
    idle(1, 0, 8'hC0, 32'h12345678);
    // Timeout: abort visible after the 8th idle edge following 8'hAA.
    v(0, 1, 8'h81, 0, 1, 0, 5'b0, 8'hC0, 32'h12345678);
    v(0, 1, 8'hAA, 0, 1, 0, 5'b0, 8'hC0, 32'h12345678);
    idle(TMO - 1, 1, 8'hC0, 32'h12345678);
    v(0, 0, 8'h00, 0, 0, 1, 5'b0, 8'hC0, 32'h12345678);
    idle(1, 0, 8'hC0, 32'h12345678);
    v(0, 1, 8'h01, 1, 0, 0, 5'b01000, 8'h01, 32'h12345678);
    // Back-to-back soft resets.
    for (int i = 0; i < 5; i++) v(0, 1, 8'h00, 1, 0, 0, 5'b10000, 8'h00, 32'h12345678);
    idle(1, 0, 8'h00, 32'h12345678);
    // Long command, every later byte lands in the exact expiry cycle.
    v(0, 1, 8'hC3, 0, 1, 0, 5'b0, 8'h00, 32'h12345678);
    v(0, 1, 8'h11, 0, 1, 0, 5'b0, 8'h00, 32'h12345678);
    idle(TMO - 1, 1, 8'h00, 32'h12345678);
    v(0, 1, 8'h22, 0, 1, 0, 5'b0, 8'h00, 32'h12345678);
    idle(TMO - 1, 1, 8'h00, 32'h12345678);
    v(0, 1, 8'h33, 0, 1, 0, 5'b0, 8'h00, 32'h12345678);
    idle(TMO - 1, 1, 8'h00, 32'h12345678);
    v(0, 1, 8'h44, 1, 0, 0, 5'b0, 8'hC3, 32'h44332211);
    // Finish, undefined short opcode, then long start right behind a short.
    v(0, 1, 8'h05, 1, 0, 0, 5'b00001, 8'h05, 32'h44332211);
    v(0, 1, 8'h7F, 1, 0, 0, 5'b00000, 8'h7F, 32'h44332211);
    v(0, 1, 8'h03, 1, 0, 0, 5'b00000, 8'h03, 32'h44332211);
    // Reset after two data bytes, then query_id.
    v(0, 1, 8'h85, 0, 1, 0, 5'b0, 8'h03, 32'h44332211);
    v(0, 1, 8'hA1, 0, 1, 0, 5'b0, 8'h03, 32'h44332211);
    v(0, 1, 8'hA2, 0, 1, 0, 5'b0, 8'h03, 32'h44332211);
    v(1, 0, 8'h00, 0, 0, 0, 5'b0, 8'h00, 32'h0);
    idle(2, 0, 8'h00, 32'h0);
    v(0, 1, 8'h02, 1, 0, 0, 5'b00100, 8'h02, 32'h0);
    idle(TMO + 2, 0, 8'h02, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      ext_reset = vecs[i].rst;
      rx_valid  = vecs[i].vld;
      rx_byte   = vecs[i].byt;
      @(posedge clk);
      #1;
      check($sformatf("row%0d execute", i), 32'(execute), 32'(vecs[i].ex));
      check($sformatf("row%0d cmd_busy", i), 32'(cmd_busy), 32'(vecs[i].busy));
      check($sformatf("row%0d cmd_abort", i), 32'(cmd_abort), 32'(vecs[i].ab));
      check($sformatf("row%0d pulses", i),
            32'({soft_reset, arm, query_id, query_metadata, finish_now}), 32'(vecs[i].pulses));
      check($sformatf("row%0d opcode", i), 32'(opcode), 32'(vecs[i].op));
      check($sformatf("row%0d cmd_data", i), cmd_data, vecs[i].data);
    end

    // Hand-written: a lone long opcode must abort after exactly TMO idle edges
    // with no execute, and a short command afterwards still works.
    begin
      int  edges;
      bit  seen_abort;
      bit  seen_exec;
      edges = 0; seen_abort = 0; seen_exec = 0;
      @(negedge clk);
      rx_valid = 1'b1; rx_byte = 8'h90;
      @(negedge clk);
      rx_valid = 1'b0; rx_byte = 8'h00;
      while (!seen_abort && edges < 20) begin
        @(posedge clk);
        #1;
        edges++;
        if (execute) seen_exec = 1;
        if (cmd_abort) seen_abort = 1;
      end
      check("abort_seen", 32'(seen_abort), 32'd1);
      check("abort_latency", edges, TMO);
      check("abort_no_execute", 32'(seen_exec), 32'd0);
      @(posedge clk);
      #1;
      check("abort_one_cycle", 32'(cmd_abort), 32'd0);
      check("abort_busy_low", 32'(cmd_busy), 32'd0);
      @(negedge clk);
      rx_valid = 1'b1; rx_byte = 8'h04;
      @(posedge clk);
      #1;
      check("post_abort_execute", 32'(execute), 32'd1);
      check("post_abort_meta", 32'(query_metadata), 32'd1);
      check("post_abort_data", cmd_data, 32'h0);
      @(negedge clk);
      rx_valid = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sump_cmd_decoder.md
Name: sump_cmd_decoder

Overview:
- Receive-side counterpart of the metadata transmit path.
- Takes the byte stream delivered by the SPI receiver and frames it into SUMP commands.
  - Short: 1 byte, opcode[7]=0.
  - Long: opcode[7]=1, followed by 4 data bytes.
- Issues a registered execute strobe with opcode and 32-bit data, plus decoded one-cycle pulses for the short commands the core consumes, including query_metadata for the metadata sender.
- Aborts and resynchronises on an inter-byte timeout.

Parameters:
TIMEOUT_CYCLES, 50000, idle clocks allowed between bytes of a long command before the partial command is discarded (1..65535)

Ports:
clock  input  1  system clock; all logic on rising edge
extReset  input  1  reset, synchronous, active-high
rx_byte  input  8  received byte; valid only when rx_valid=1
rx_valid  input  1  one-cycle strobe per received byte
opcode  output  8  opcode of last executed command
cmd_data  output  32  data of last long command; first received data byte = bits[7:0]
execute  output  1  one-cycle pulse: opcode/cmd_data hold a new complete command
cmd_busy  output  1  high while a long command is partially received
cmd_abort  output  1  one-cycle pulse: partial long command discarded on timeout
soft_reset  output  1  pulse on opcode 8'h00
arm  output  1  pulse on opcode 8'h01
query_id  output  1  pulse on opcode 8'h02
query_metadata  output  1  pulse on opcode 8'h04
finish_now  output  1  pulse on opcode 8'h05

Behaviour:
- Reset (extReset=1 at a rising edge): state=IDLE; byte_cnt=0; timeout counter=0. All outputs 0, including opcode and cmd_data.
- extReset has priority over every other event. Reset mid-command discards the partial command with no execute and no abort pulse.
- FSM states: IDLE, GETDATA.
- IDLE, rx_valid with rx_byte[7]=0 (short command):
  - opcode<=rx_byte; cmd_data unchanged.
  - execute pulses in the next cycle.
  - Matching decoded pulse asserts in the same cycle as execute.
  - Undefined short opcodes raise execute only.
- IDLE, rx_valid with rx_byte[7]=1 (long command):
  - Opcode captured into a shadow register; byte_cnt<=0; state<=GETDATA; cmd_busy<=1.
- GETDATA, rx_valid:
  - Byte stored into data shadow lane byte_cnt (bits 8*byte_cnt+7 : 8*byte_cnt); byte_cnt increments; timeout counter cleared.
  - On the 4th data byte (byte_cnt=3): opcode and cmd_data load from the shadows; execute pulses next cycle; state<=IDLE; cmd_busy<=0.
- Latency: rx_valid of the final byte in cycle N -> execute=1 in cycle N+1.
- opcode and cmd_data only change on the edge that raises execute. They are stable until the next execute.
- Decoded pulses are never raised for long opcodes.
- Timeout:
  - In GETDATA, the 16-bit counter increments on every cycle without rx_valid.
  - When it reaches TIMEOUT_CYCLES: state<=IDLE, cmd_busy<=0, shadows discarded, cmd_abort pulses for one cycle, no execute.
  - rx_valid in the same cycle the counter would expire: the byte wins; counter cleared; no abort.
- A byte arriving in the cycle execute is high is processed normally. Back-to-back commands at one byte per clock are supported without loss.
- Counter is held at 0 in IDLE.
- At most one decoded pulse is high in any cycle. Pulses coincide exactly with execute.
- A new command's execute overrides nothing pending: there is no queue, and every command executes exactly once.

Test Plan:
1. Reset, then byte 8'h04 at cycle 10 -> execute=1 and query_metadata=1 at cycle 11 only; opcode=8'h04; cmd_data=0.
2. Bytes 8'hC0,8'h78,8'h56,8'h34,8'h12 on consecutive clocks -> cmd_busy high from the 2nd cycle; one execute after the last byte; opcode=8'hC0; cmd_data=32'h12345678; no decoded pulse.
3. TIMEOUT_CYCLES=8; send 8'h81,8'hAA then silence -> cmd_abort pulses once, 8 idle cycles after 8'hAA; no execute; a following 8'h01 yields execute plus arm, with cmd_data unchanged from prior value.
4. Five 8'h00 bytes back-to-back -> five consecutive execute+soft_reset pulses, each one cycle after its byte.
5. Long command with its last byte arriving in the exact expiry cycle (gap of TIMEOUT_CYCLES-1) -> execute, no cmd_abort.
6. extReset asserted after 2 data bytes of a long command, then 8'h02 -> no execute for the partial command; query_id pulse; opcode=8'h02; cmd_data=0.
